// File: rtl/nine_segment_scan_ctrl.sv
// Row-scanned driver for the 3x3 nine-segment LED matrix, with blanking between rows
// and frame-aligned pattern updates. Define BRIGHTNESS_EN for the PWM brightness input.
module nine_segment_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] segments,
    input  logic       pattern_valid,
    output logic       pattern_ready,
    output logic [2:0] rows,
    output logic [2:0] cols,
`ifdef BRIGHTNESS_EN
    input  logic [3:0] brightness,
`endif
    output logic       frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       active_q, active_d;
    logic [8:0]       pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic             frame_start_q, frame_start_d;
    logic             lit;

    function automatic logic [2:0] row_bits(input logic [8:0] pat, input logic [1:0] r);
        case (r)
            2'd0:    row_bits = pat[2:0];
            2'd1:    row_bits = pat[5:3];
            default: row_bits = pat[8:6];
        endcase
    endfunction

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        cnt_d          = cnt_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_start_d  = 1'b0;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (row_q == 2'd2) begin
                        // Frame boundary: the only point a new pattern may go live.
                        row_d         = 2'd0;
                        frame_start_d = 1'b1;
                        if (pending_full_q) begin
                            active_d       = pending_q;
                            pending_full_d = 1'b0;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // Accept cannot collide with commit: commit needs pending_full, which blocks ready.
        if (pattern_valid && !pending_full_q) begin
            pending_d      = segments;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= BLANK;
            row_q          <= 2'd0;
            cnt_q          <= '0;
            active_q       <= 9'd0;
            pending_full_q <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            cnt_q          <= cnt_d;
            active_q       <= active_d;
            pending_full_q <= pending_full_d;
            frame_start_q  <= frame_start_d;
        end
    end

    always_ff @(posedge clk) begin
        pending_q <= pending_d;
    end

`ifdef BRIGHTNESS_EN
    logic [3:0] pwm_q, pwm_d;

    // Zero during BLANK so the first DRIVE cycle always sees pwm=0.
    always_comb begin
        pwm_d = (state_q == DRIVE) ? pwm_q + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign lit = (state_q == DRIVE) && (pwm_q <= brightness);
`else
    assign lit = (state_q == DRIVE);
`endif

    always_comb begin
        rows = 3'b000;
        cols = 3'b111;
        if (lit) begin
            rows = 3'b001 << row_q;
            cols = ~row_bits(active_q, row_q);
        end
    end

    assign pattern_ready = !pending_full_q;
    assign frame_start   = frame_start_q;

endmodule
